// File: rtl/data_mem_ctrl_if.sv
// Memory-stage access bus between the pipeline and the data memory controller.
// The core drives the request side (master); the controller answers (slave).
interface data_mem_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic        byte_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        done_o;
    logic        fault_o;

    modport master (
        output req_i, we_i, byte_i, addr_i, wdata_i,
        input  rdata_o, stall_o, done_o, fault_o
    );

    modport slave (
        input  req_i, we_i, byte_i, addr_i, wdata_i,
        output rdata_o, stall_o, done_o, fault_o
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller for the memory stage: single-cycle stores, loads with
// a programmable read latency that stall the pipeline, byte and word accesses,
// and a fault pulse for out-of-range or misaligned accesses.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic            clk,
    input logic            reset,
    data_mem_ctrl_if.slave bus
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        byte_q;
    logic [1:0]  lane_q;
    logic [31:0] ram_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          legal;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          accept_load;
    logic          accept_store;
    logic [7:0]    ram_byte;

    // The offset is a plain 32-bit unsigned difference, so addresses below the
    // base wrap to huge values and fall out of range instead of aliasing.
    assign offset       = bus.addr_i - BASE_ADDR;
    assign legal        = (offset < SPAN) && (bus.byte_i || (bus.addr_i[1:0] == 2'b00));
    assign idx          = offset[AW+1:2];
    assign lane         = bus.addr_i[1:0];
    assign accept_load  = !reset && (state == IDLE) && bus.req_i && !bus.we_i && legal;
    assign accept_store = !reset && (state == IDLE) && bus.req_i && bus.we_i && legal;
    assign ram_byte     = ram_q[{lane_q, 3'b000} +: 8];

    // The stall must rise in the accept cycle itself so the core freezes
    // before the next edge; afterwards it follows the BUSY state.
    assign bus.stall_o = (state == BUSY) || accept_load;

    // RAM array: stores land on the accept edge, loads capture the addressed
    // word on their accept edge; no reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (accept_store) begin
            if (bus.byte_i) begin
                mem[idx][{lane, 3'b000} +: 8] <= bus.wdata_i[7:0];
            end else begin
                mem[idx] <= bus.wdata_i;
            end
        end
        if (accept_load) begin
            ram_q <= mem[idx];
        end
    end

    // Access sequencer: samples requests only in IDLE, counts the read
    // latency in BUSY and presents load data with done_o in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            byte_q      <= 1'b0;
            lane_q      <= 2'b00;
            bus.rdata_o <= 32'h0;
            bus.done_o  <= 1'b0;
            bus.fault_o <= 1'b0;
        end else begin
            bus.done_o  <= 1'b0;
            bus.fault_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_i) begin
                        if (!legal) begin
                            bus.fault_o <= 1'b1;
                        end else if (bus.we_i) begin
                            bus.done_o <= 1'b1;
                        end else begin
                            state  <= BUSY;
                            cnt    <= 3'd0;
                            byte_q <= bus.byte_i;
                            lane_q <= lane;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == LAT_LAST) begin
                        state      <= RESP;
                        cnt        <= 3'd0;
                        bus.done_o <= 1'b1;
                        if (byte_q) begin
                            bus.rdata_o <= {24'h0, ram_byte};
                        end else begin
                            bus.rdata_o <= ram_q;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: four controllers with read latencies 1..4 share
// one stimulus stream; a schedule-based model per instance predicts every
// cycle's outputs, and literal expectations pin the key scenarios.
module tb_data_mem_ctrl;

    localparam int          DEPTH = 64;
    localparam int          NINST = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        byt = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] dRdata [NINST];
    logic        dStall [NINST];
    logic        dDone  [NINST];
    logic        dFault [NINST];

    // free-running clock
    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : gInst
        data_mem_ctrl_if bus ();
        assign bus.req_i   = req;
        assign bus.we_i    = we;
        assign bus.byte_i  = byt;
        assign bus.addr_i  = addr;
        assign bus.wdata_i = wdata;
        assign dRdata[g]   = bus.rdata_o;
        assign dStall[g]   = bus.stall_o;
        assign dDone[g]    = bus.done_o;
        assign dFault[g]   = bus.fault_o;

        data_mem_ctrl #(
            .DEPTH_WORDS(DEPTH),
            .RD_LAT(g + 1),
            .BASE_ADDR(BASE)
        ) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus)
        );
    end

    // Model: per instance, the cycle numbers at which events are due.
    int          readyAt    [NINST];
    int          stallUntil [NINST];
    int          doneAt     [NINST];
    int          faultAt    [NINST];
    int          loadAt     [NINST];
    logic [31:0] pend       [NINST];
    logic [31:0] expRdata   [NINST];
    logic [31:0] mMem       [NINST][DEPTH];

    // Observations used by the literal checks.
    logic [31:0] doneData [NINST];
    int          curRun   [NINST];
    int          lastRun  [NINST];
    int          doneCnt  [NINST];
    int          faultCnt [NINST];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    task automatic clearSchedule(input int k);
        readyAt[k]    = 0;
        stallUntil[k] = 0;
        doneAt[k]     = -1;
        faultAt[k]    = -1;
        loadAt[k]     = -1;
        expRdata[k]   = 32'h0;
    endtask

    task automatic checkOutput();
        logic        accept, legal, isLoad, eStall, eDone, eFault;
        logic [31:0] off, word;
        int          idx, sh, lat;
        cyc++;
        for (int k = 0; k < NINST; k++) begin
            lat = k + 1;
            accept = 1'b0;
            isLoad = 1'b0;
            legal  = 1'b0;
            off    = addr - BASE;
            idx    = 0;
            sh     = 0;
            if (reset) begin
                clearSchedule(k);
                eStall = 1'b0;
                eDone  = 1'b0;
                eFault = 1'b0;
            end else begin
                if (cyc == loadAt[k]) expRdata[k] = pend[k];
                accept = (cyc >= readyAt[k]) && req;
                legal  = (off < 32'(4 * DEPTH)) && (byt || (addr[1:0] == 2'b00));
                isLoad = accept && legal && !we;
                eStall = (cyc < stallUntil[k]) || isLoad;
                eDone  = (cyc == doneAt[k]);
                eFault = (cyc == faultAt[k]);
            end
            total++;
            if (dStall[k] !== eStall || dDone[k] !== eDone || dFault[k] !== eFault ||
                dRdata[k] !== expRdata[k]) begin
                bad++;
                $display("[TB] FAIL cycle-compare inst%0d cyc=%0d got stall=%b done=%b fault=%b rdata=%h expected stall=%b done=%b fault=%b rdata=%h",
                         k, cyc, dStall[k], dDone[k], dFault[k], dRdata[k],
                         eStall, eDone, eFault, expRdata[k]);
            end
            if (accept) begin
                idx = int'(off >> 2);
                sh  = int'(addr[1:0]) * 8;
                if (!legal) begin
                    faultAt[k] = cyc + 1;
                end else if (we) begin
                    word = mMem[k][idx];
                    if (byt) word[sh +: 8] = wdata[7:0];
                    else     word = wdata;
                    mMem[k][idx] = word;
                    doneAt[k] = cyc + 1;
                end else begin
                    word = mMem[k][idx];
                    pend[k]       = byt ? {24'h0, word[sh +: 8]} : word;
                    loadAt[k]     = cyc + lat + 1;
                    doneAt[k]     = cyc + lat + 1;
                    stallUntil[k] = cyc + lat + 1;
                    readyAt[k]    = cyc + lat + 2;
                end
            end
            if (dStall[k] === 1'b1) begin
                curRun[k]++;
            end else begin
                if (curRun[k] > 0) lastRun[k] = curRun[k];
                curRun[k] = 0;
            end
            if (dDone[k] === 1'b1) begin
                doneCnt[k]++;
                doneData[k] = dRdata[k];
            end
            if (dFault[k] === 1'b1) faultCnt[k]++;
        end
    endtask

    task automatic checkLiteral(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic b,
                                 input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        req = r; we = w; byt = b; addr = a; wdata = d;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Directed scenarios followed by a randomized stream.
    initial begin
        int f0, d0, dc;
        logic r, w, b;
        logic [31:0] a;
        int sel;
        for (int k = 0; k < NINST; k++) begin
            clearSchedule(k);
            doneData[k] = 32'h0;
            curRun[k]   = 0;
            lastRun[k]  = 0;
            doneCnt[k]  = 0;
            faultCnt[k] = 0;
        end

        repeat (2) begin
            @(negedge clk);
            checkOutput();
        end
        for (int k = 0; k < NINST; k++) begin
            checkLiteral("reset rdata", dRdata[k], 32'h0);
            checkLiteral("reset stall/done/fault", {29'h0, dStall[k], dDone[k], dFault[k]}, 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput();

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'(i * 4), $urandom);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        idle(7);
        checkLiteral("word load lat2", doneData[1], 32'hDEADBEEF);
        checkLiteral("stall length lat1", 32'(lastRun[0]), 32'd2);
        checkLiteral("stall length lat2", 32'(lastRun[1]), 32'd3);
        checkLiteral("stall length lat4", 32'(lastRun[3]), 32'd5);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h11, 32'hFFFF_FFA5);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        idle(7);
        checkLiteral("word after byte store lat1", doneData[0], 32'h0000A500);
        checkLiteral("word after byte store lat4", doneData[3], 32'h0000A500);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h11, 32'h0);
        idle(7);
        checkLiteral("byte load lat1", doneData[0], 32'h000000A5);
        checkLiteral("byte load lat4", doneData[3], 32'h000000A5);

        f0 = faultCnt[0];
        d0 = doneCnt[0];
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h13, 32'h0);
        idle(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'(4 * DEPTH), 32'hFFFF_FFFF);
        idle(2);
        checkLiteral("fault pulses", 32'(faultCnt[0] - f0), 32'd2);
        checkLiteral("no done on faults", 32'(doneCnt[0] - d0), 32'd0);
        checkLiteral("rdata held over faults", dRdata[0], 32'h000000A5);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(7);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        idle(7);
        checkLiteral("store then load lat1", doneData[0], 32'h1);
        checkLiteral("store then load lat4", doneData[3], 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h2);
        idle(3);
        checkLiteral("load then store lat1", doneData[0], 32'h1);
        checkLiteral("load then store lat4", doneData[3], 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        idle(7);
        checkLiteral("later load sees store", doneData[2], 32'h2);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h30, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        idle(1);
        dc = doneCnt[2];
        @(posedge clk);
        #1;
        checkLiteral("stall before reset lat3", {31'h0, dStall[2]}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        checkLiteral("stall drops on reset", {31'h0, dStall[2]}, 32'h0);
        checkLiteral("rdata cleared on reset", dRdata[2], 32'h0);
        checkLiteral("done low on reset", {31'h0, dDone[2]}, 32'h0);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput();
        idle(6);
        checkLiteral("aborted load has no done", 32'(doneCnt[2] - dc), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        idle(7);
        checkLiteral("reload after reset", doneData[2], 32'h1234_5678);
        checkLiteral("single done after reload", 32'(doneCnt[2] - dc), 32'd1);

        repeat (800) begin
            r   = ($urandom_range(0, 9) < 6);
            w   = 1'($urandom_range(0, 1));
            b   = ($urandom_range(0, 9) < 3);
            sel = int'($urandom_range(0, 19));
            if (sel == 0)      a = 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
            else if (sel == 1) a = 32'h8000_0000 | $urandom;
            else               a = 32'($urandom_range(0, 4 * DEPTH - 1));
            if (!b && $urandom_range(0, 9) < 8) a[1:0] = 2'b00;
            applyStimulus(r, w, b, a, $urandom);
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in internal data RAM; power of two, range 64..65536.
REQ-002 Parameter RD_LAT, default 1: read latency in clocks from request acceptance to data; range 1..4.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address mapped to word 0.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_i  input  1  memory-stage access request valid.
REQ-007 we_i  input  1  1 = store, 0 = load; qualified by req_i.
REQ-008 byte_i  input  1  1 = byte access (LDRB/STRB), 0 = word access.
REQ-009 addr_i  input  32  byte address.
REQ-010 wdata_i  input  32  store data; for byte stores, bits [7:0] are used.
REQ-011 rdata_o  output  32  load result, held until the next completed load.
REQ-012 stall_o  output  1  pipeline stall; the core freezes the memory stage and earlier stages while high.
REQ-013 done_o  output  1  one-cycle pulse when an access completes.
REQ-014 fault_o  output  1  one-cycle pulse instead of done_o on an illegal access.

Function
REQ-015 FSM states IDLE, BUSY, RESP; only IDLE samples req_i, we_i, byte_i, addr_i and wdata_i.
REQ-016 Legal access: (addr_i - BASE_ADDR) < 4*DEPTH_WORDS, and for word accesses addr_i[1:0] = 2'b00; any other access is illegal.
REQ-017 Legal store in IDLE: the RAM is written on the same edge; done_o pulses in the next cycle; stall_o stays 0; the FSM stays in IDLE.
REQ-018 Word store writes all four byte lanes.
REQ-019 Byte store writes wdata_i[7:0] only to lane addr_i[1:0] (little-endian); the other three lanes are unchanged.
REQ-020 Legal load in IDLE: IDLE->BUSY; stall_o = 1 combinationally in the accept cycle and in each following cycle until RESP.
REQ-021 The latency counter counts RD_LAT cycles in BUSY, then the FSM moves to RESP.
REQ-022 In RESP: rdata_o is updated, done_o = 1, stall_o = 0, and the next state is IDLE.
REQ-023 Total load stall is RD_LAT+1 cycles including the accept cycle.
REQ-024 Word load returns the full word.
REQ-025 Byte load returns the byte at lane addr_i[1:0], zero-extended to 32 bits.
REQ-026 Illegal access (load or store): no RAM write; fault_o pulses in the next cycle; rdata_o is unchanged; stall_o = 0; the FSM stays in IDLE.
REQ-027 Back-to-back accesses: a request present in the cycle RESP->IDLE is accepted in the following IDLE cycle. Sustained load rate is one per RD_LAT+2 cycles; sustained store rate is one per cycle.
REQ-028 Load followed by a store to the same address: the load returns the pre-store data.
REQ-029 Store followed by a load to the same address in the next cycle: the load returns the stored data.
REQ-030 req_i toggling while in BUSY or RESP is ignored and has no effect.
REQ-031 Address wrap-around is not performed: an offset at or beyond 4*DEPTH_WORDS is illegal, never aliased.
REQ-032 RAM index = (addr_i - BASE_ADDR)[log2(4*DEPTH_WORDS)-1:2]; the subtraction is 32-bit unsigned, so addresses below BASE_ADDR are illegal.
REQ-033 RAM contents are uninitialised at power-up unless preloaded by simulation init.

Reset
REQ-034 reset = 1 forces, asynchronously: state = IDLE, counter = 0, rdata_o = 0, stall_o = 0, done_o = 0, fault_o = 0.
REQ-035 Reset during BUSY aborts the load: no done_o, and stall_o drops immediately.
REQ-036 Reset does not clear RAM contents.
REQ-037 After reset deassertion, the first rising edge may accept a request.

Verification
REQ-038 Store word 32'hDEADBEEF at 0x10, then word load at 0x10 with RD_LAT = 2 -> stall_o high 3 cycles, then done_o = 1 with rdata_o = 32'hDEADBEEF.
REQ-039 STRB 8'hA5 at 0x11 over word 32'h00000000, then word load at 0x10 -> 32'h0000A500; LDRB at 0x11 -> 32'h000000A5.
REQ-040 Word load at 0x13, and store at 4*DEPTH_WORDS -> fault_o pulse each, no done_o, RAM unchanged, rdata_o unchanged.
REQ-041 Store 32'h1 at 0x20 at cycle n, load 0x20 at cycle n+1 -> rdata_o = 32'h1; load issued first, then store 32'h2 -> load returns 32'h1.
REQ-042 Assert reset in the second BUSY cycle with RD_LAT = 3 -> stall_o = 0 and rdata_o = 0 immediately, no done_o; a reload then returns the original data.
REQ-043 Sweep RD_LAT = 1..4 with 100 random legal loads and stores checked against a reference model -> zero mismatches, and each load stall = RD_LAT+1.
